unidade_de_busca: RTL

// - Instruction fetch unit; reader side of the program counter. Samples PC value, issues one word read to

---
 rtl/unidade_de_busca_pkg.sv | 19 +
 rtl/unidade_de_busca_if.sv | 14 +
 rtl/unidade_de_busca_fila.sv | 75 +++++++
 rtl/unidade_de_busca.sv | 118 +++++++++++
 4 files changed

// File: rtl/unidade_de_busca_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, widths and
// the {pc, instr} entry stored in the prefetch FIFO.
package pkg_busca;

    localparam int LARGURA_END   = 26;
    localparam int LARGURA_INSTR = 32;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        AGUARDA  = 2'd1,
        DESCARTA = 2'd2
    } estado_t;

    typedef struct packed {
        logic [LARGURA_END-1:0]   pc;
        logic [LARGURA_INSTR-1:0] instr;
    } entrada_fifo_t;

endpackage

// File: rtl/unidade_de_busca_if.sv
// Instruction-memory read port: one word per req/ack handshake.
// master = fetch unit, slave = instruction memory.
interface unidade_de_busca_if;
    import pkg_busca::*;

    logic                     mem_req;
    logic [LARGURA_END-1:0]   mem_end;
    logic                     mem_ack;
    logic [LARGURA_INSTR-1:0] mem_dado;

    modport master (output mem_req, output mem_end, input mem_ack, input mem_dado);
    modport slave  (input mem_req, input mem_end, output mem_ack, output mem_dado);

endinterface

// File: rtl/unidade_de_busca_fila.sv
// fila_busca: synchronous prefetch FIFO of {pc, instr} entries with push, pop
// and a clear (limpa) that wins over both.
module fila_busca
    import pkg_busca::*;
#(
    parameter int PROFUNDIDADE = 4,
    localparam int LARG_PTR  = $clog2(PROFUNDIDADE),
    localparam int LARG_CONT = LARG_PTR + 1
)
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push_i,
    input  entrada_fifo_t        dado_i,
    input  logic                 pop_i,
    input  logic                 limpa_i,
    output entrada_fifo_t        cabeca_o,
    output logic [LARG_CONT-1:0] contagem_o,
    output logic                 cheia_o
);

    entrada_fifo_t        memoria_q [PROFUNDIDADE];
    entrada_fifo_t        ultima_q;
    logic [LARG_PTR-1:0]  leitura_q;
    logic [LARG_PTR-1:0]  escrita_q;
    logic [LARG_CONT-1:0] contagem_q;
    logic                 vazia;
    logic                 faz_push;
    logic                 faz_pop;

    assign vazia      = (contagem_q == '0);
    assign cheia_o    = (contagem_q == LARG_CONT'(PROFUNDIDADE));
    assign contagem_o = contagem_q;
    assign faz_pop    = pop_i && !limpa_i && !vazia;
    assign faz_push   = push_i && !limpa_i && (!cheia_o || faz_pop);

    // When empty the head shows the last entry that left, so decode sees a stable value.
    assign cabeca_o = vazia ? ultima_q : memoria_q[leitura_q];

    always_ff @(posedge clock) begin
        if (faz_push) begin
            memoria_q[escrita_q] <= dado_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leitura_q  <= '0;
            escrita_q  <= '0;
            contagem_q <= '0;
            ultima_q   <= '0;
        end else if (limpa_i) begin
            leitura_q  <= '0;
            escrita_q  <= '0;
            contagem_q <= '0;
            if (!vazia) begin
                ultima_q <= memoria_q[leitura_q];
            end
        end else begin
            if (faz_push) begin
                escrita_q <= escrita_q + 1'b1;
            end
            if (faz_pop) begin
                leitura_q <= leitura_q + 1'b1;
                ultima_q  <= memoria_q[leitura_q];
            end
            case ({faz_push, faz_pop})
                2'b10:   contagem_q <= contagem_q + 1'b1;
                2'b01:   contagem_q <= contagem_q - 1'b1;
                default: contagem_q <= contagem_q;
            endcase
        end
    end

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch unit: reads one word at pc_atual, queues {pc, instr} for decode.
// Optional: define BUSCA_CONTADOR_EN to add the ciclos_parada stall counter port.
module unidade_de_busca
    import pkg_busca::*;
#(
    parameter int PROFUNDIDADE = 4
)
(
    input  logic                     clock,
    input  logic                     busca_reset,
    input  logic [LARGURA_END-1:0]   pc_atual,
    output logic                     pc_avanca,
    unidade_de_busca_if.master       mem,
    output logic                     instr_valida,
    output logic [LARGURA_INSTR-1:0] instr,
    output logic [LARGURA_END-1:0]   instr_pc,
    input  logic                     instr_pronta,
    input  logic                     descarte
`ifdef BUSCA_CONTADOR_EN
    ,output logic [31:0]             ciclos_parada
`endif
);

    localparam int LARG_CONT = $clog2(PROFUNDIDADE) + 1;

    estado_t                estado_q, estado_d;
    logic                   mem_req_q, mem_req_d;
    logic [LARGURA_END-1:0] mem_end_q, mem_end_d;
    logic                   push;
    logic                   cheia;
    logic [LARG_CONT-1:0]   contagem;
    entrada_fifo_t          entrada;
    entrada_fifo_t          cabeca;

    assign entrada      = '{pc: mem_end_q, instr: mem.mem_dado};
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_end  = mem_end_q;
    assign instr_valida = (contagem != '0);
    assign instr        = cabeca.instr;
    assign instr_pc     = cabeca.pc;

    fila_busca #(.PROFUNDIDADE(PROFUNDIDADE)) u_fila (
        .clock      (clock),
        .reset      (busca_reset),
        .push_i     (push),
        .dado_i     (entrada),
        .pop_i      (instr_valida && instr_pronta),
        .limpa_i    (descarte),
        .cabeca_o   (cabeca),
        .contagem_o (contagem),
        .cheia_o    (cheia)
    );

    always_ff @(posedge clock or posedge busca_reset) begin
        if (busca_reset) begin
            estado_q  <= OCIOSO;
            mem_req_q <= 1'b0;
            mem_end_q <= '0;
        end else begin
            estado_q  <= estado_d;
            mem_req_q <= mem_req_d;
            mem_end_q <= mem_end_d;
        end
    end

    // A flushed request stays open until memory answers; its data is then dropped.
    always_comb begin
        estado_d  = estado_q;
        mem_req_d = mem_req_q;
        mem_end_d = mem_end_q;
        push      = 1'b0;
        pc_avanca = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (!descarte && !cheia) begin
                    estado_d  = AGUARDA;
                    mem_req_d = 1'b1;
                    mem_end_d = pc_atual;
                end
            end
            AGUARDA: begin
                if (mem.mem_ack) begin
                    estado_d  = OCIOSO;
                    mem_req_d = 1'b0;
                    push      = !descarte;
                    pc_avanca = !descarte;
                end else if (descarte) begin
                    estado_d = DESCARTA;
                end
            end
            DESCARTA: begin
                if (mem.mem_ack) begin
                    estado_d  = OCIOSO;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                estado_d  = OCIOSO;
                mem_req_d = 1'b0;
            end
        endcase
    end

`ifdef BUSCA_CONTADOR_EN
    logic [31:0] ciclos_parada_q;

    always_ff @(posedge clock or posedge busca_reset) begin
        if (busca_reset) begin
            ciclos_parada_q <= '0;
        end else if (!instr_valida && !descarte && (ciclos_parada_q != '1)) begin
            ciclos_parada_q <= ciclos_parada_q + 32'd1;
        end
    end

    assign ciclos_parada = ciclos_parada_q;
`endif

endmodule
